// File: rtl/ex_muldiv_unit.sv
// Iterative multiply/divide unit for the EX stage: radix-2 shift-add multiply,
// restoring divide, sign fix-up in a final cycle, and the architectural HI/LO pair.
module ex_muldiv_unit #(
    parameter int DATA_WIDTH = 32,
    parameter int CNT_WIDTH  = 5
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  start_i,
    input  logic [1:0]            op_i,
    input  logic [DATA_WIDTH-1:0] data1_i,
    input  logic [DATA_WIDTH-1:0] data2_i,
    input  logic                  mthi_i,
    input  logic                  mtlo_i,
    input  logic                  flush_i,
    output logic                  busy_o,
    output logic                  done_o,
    output logic [DATA_WIDTH-1:0] hi_o,
    output logic [DATA_WIDTH-1:0] lo_o
);

    localparam int W = DATA_WIDTH;
    localparam logic [W-1:0]         ZERO_W   = {W{1'b0}};
    localparam logic [W-1:0]         ONES_W   = {W{1'b1}};
    localparam logic [W-1:0]         ONE_W    = {{(W-1){1'b0}}, 1'b1};
    localparam logic [2*W-1:0]       ONE_2W   = {{(2*W-1){1'b0}}, 1'b1};
    localparam logic [CNT_WIDTH-1:0] ZERO_CNT = {CNT_WIDTH{1'b0}};
    localparam logic [CNT_WIDTH-1:0] ONE_CNT  = {{(CNT_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(DATA_WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FIX  = 2'd2
    } state_t;

    function automatic logic [W-1:0] neg_w_f(input logic [W-1:0] v, input logic neg);
        if (neg) begin
            neg_w_f = ~v + ONE_W;
        end else begin
            neg_w_f = v;
        end
    endfunction

    function automatic logic [2*W-1:0] neg_2w_f(input logic [2*W-1:0] v, input logic neg);
        if (neg) begin
            neg_2w_f = ~v + ONE_2W;
        end else begin
            neg_2w_f = v;
        end
    endfunction

    state_t                 state_q, state_d;
    logic [CNT_WIDTH-1:0]   cnt_q, cnt_d;
    logic [1:0]             op_q, op_d;
    logic                   sign1_q, sign1_d;
    logic                   sign2_q, sign2_d;
    // mul: multiplicand magnitude; div: divisor magnitude
    logic [W-1:0]           opa_q, opa_d;
    // mul: {partial product, remaining multiplier}; div: low half is dividend/quotient
    logic [2*W-1:0]         acc_q, acc_d;
    logic [W:0]             rem_q, rem_d;
    logic [W-1:0]           hi_q, hi_d;
    logic [W-1:0]           lo_q, lo_d;
    logic                   done_q, done_d;

    logic                   is_signed_s;
    logic                   in_sign1_s, in_sign2_s;
    logic [W-1:0]           in_mag1_s, in_mag2_s;
    logic [W:0]             mul_sum_s;
    logic [2*W-1:0]         mul_acc_s;
    logic [W:0]             rem_shift_s;
    logic [W+1:0]           div_diff_s;
    logic [2*W-1:0]         prod_fix_s;
    logic [W-1:0]           quo_fix_s;
    logic [W-1:0]           rem_fix_s;

    // State register
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; flush beats both start and FIX completion
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (start_i && !flush_i) begin
                    state_d = S_CALC;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_CALC: begin
                if (flush_i) begin
                    state_d = S_IDLE;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = S_FIX;
                end else begin
                    state_d = S_CALC;
                end
            end
            S_FIX:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Output decode from state
    always_comb begin
        busy_o = (state_q != S_IDLE);
    end

    assign done_o = done_q;
    assign hi_o   = hi_q;
    assign lo_o   = lo_q;

    // Operand conditioning and per-iteration arithmetic
    always_comb begin
        is_signed_s = ~op_i[0];
        in_sign1_s  = is_signed_s & data1_i[W-1];
        in_sign2_s  = is_signed_s & data2_i[W-1];
        in_mag1_s   = neg_w_f(data1_i, in_sign1_s);
        in_mag2_s   = neg_w_f(data2_i, in_sign2_s);

        mul_sum_s   = {1'b0, acc_q[2*W-1:W]} + {1'b0, (acc_q[0] ? opa_q : ZERO_W)};
        mul_acc_s   = {mul_sum_s, acc_q[W-1:1]};

        rem_shift_s = {rem_q[W-1:0], acc_q[W-1]};
        div_diff_s  = {1'b0, rem_shift_s} - {2'b00, opa_q};

        prod_fix_s  = neg_2w_f(acc_q, sign1_q ^ sign2_q);
        quo_fix_s   = neg_w_f(acc_q[W-1:0], sign1_q ^ sign2_q);
        rem_fix_s   = neg_w_f(rem_q[W-1:0], sign1_q);
    end

    // Datapath next-state
    always_comb begin
        cnt_d   = cnt_q;
        op_d    = op_q;
        sign1_d = sign1_q;
        sign2_d = sign2_q;
        opa_d   = opa_q;
        acc_d   = acc_q;
        rem_d   = rem_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        done_d  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (mthi_i) begin
                    hi_d = data1_i;
                end else begin
                    hi_d = hi_q;
                end
                if (mtlo_i) begin
                    lo_d = data1_i;
                end else begin
                    lo_d = lo_q;
                end
                if (start_i && !flush_i) begin
                    op_d    = op_i;
                    sign1_d = in_sign1_s;
                    sign2_d = in_sign2_s;
                    cnt_d   = ZERO_CNT;
                    rem_d   = {1'b0, ZERO_W};
                    if (op_i[1]) begin
                        opa_d = in_mag2_s;
                        acc_d = {ZERO_W, in_mag1_s};
                    end else begin
                        opa_d = in_mag1_s;
                        acc_d = {ZERO_W, in_mag2_s};
                    end
                end else begin
                    cnt_d = cnt_q;
                end
            end
            S_CALC: begin
                if (flush_i) begin
                    cnt_d = cnt_q;
                end else begin
                    cnt_d = cnt_q + ONE_CNT;
                    if (!op_q[1]) begin
                        acc_d = mul_acc_s;
                    end else if (!div_diff_s[W+1]) begin
                        rem_d = div_diff_s[W:0];
                        acc_d = {acc_q[2*W-1:W], acc_q[W-2:0], 1'b1};
                    end else begin
                        rem_d = rem_shift_s;
                        acc_d = {acc_q[2*W-1:W], acc_q[W-2:0], 1'b0};
                    end
                end
            end
            S_FIX: begin
                if (flush_i) begin
                    done_d = 1'b0;
                end else begin
                    done_d = 1'b1;
                    if (!op_q[1]) begin
                        hi_d = prod_fix_s[2*W-1:W];
                        lo_d = prod_fix_s[W-1:0];
                    end else if (opa_q == ZERO_W) begin
                        // zero divisor: remainder path already rebuilt the dividend
                        hi_d = rem_fix_s;
                        lo_d = ONES_W;
                    end else begin
                        hi_d = rem_fix_s;
                        lo_d = quo_fix_s;
                    end
                end
            end
            default: begin
                done_d = 1'b0;
            end
        endcase
    end

    // Datapath registers
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            cnt_q   <= ZERO_CNT;
            op_q    <= 2'b00;
            sign1_q <= 1'b0;
            sign2_q <= 1'b0;
            opa_q   <= ZERO_W;
            acc_q   <= {ZERO_W, ZERO_W};
            rem_q   <= {1'b0, ZERO_W};
            hi_q    <= ZERO_W;
            lo_q    <= ZERO_W;
            done_q  <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            sign1_q <= sign1_d;
            sign2_q <= sign2_d;
            opa_q   <= opa_d;
            acc_q   <= acc_d;
            rem_q   <= rem_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            done_q  <= done_d;
        end
    end

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Directed bench for ex_muldiv_unit: vector table for arithmetic results plus
// hand-written sequences for restart, flush, mid-operation reset and MT writes.
module tb_ex_muldiv_unit;

    localparam int W = 32;

    logic          clk_i   = 1'b0;
    logic          rst_i   = 1'b1;
    logic          start_i = 1'b0;
    logic [1:0]    op_i    = 2'b00;
    logic [W-1:0]  data1_i = 32'h0;
    logic [W-1:0]  data2_i = 32'h0;
    logic          mthi_i  = 1'b0;
    logic          mtlo_i  = 1'b0;
    logic          flush_i = 1'b0;
    logic          busy_o;
    logic          done_o;
    logic [W-1:0]  hi_o;
    logic [W-1:0]  lo_o;

    ex_muldiv_unit #(.DATA_WIDTH(32), .CNT_WIDTH(5)) dut (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .start_i (start_i),
        .op_i    (op_i),
        .data1_i (data1_i),
        .data2_i (data2_i),
        .mthi_i  (mthi_i),
        .mtlo_i  (mtlo_i),
        .flush_i (flush_i),
        .busy_o  (busy_o),
        .done_o  (done_o),
        .hi_o    (hi_o),
        .lo_o    (lo_o)
    );

    always #5 clk_i = ~clk_i;

    localparam logic [1:0] OP_MULT  = 2'b00;
    localparam logic [1:0] OP_MULTU = 2'b01;
    localparam logic [1:0] OP_DIV   = 2'b10;
    localparam logic [1:0] OP_DIVU  = 2'b11;

    typedef struct {
        string       name;
        logic [1:0]  op;
        logic [W-1:0] d1;
        logic [W-1:0] d2;
        logic [W-1:0] hi;
        logic [W-1:0] lo;
    } vec_t;

    vec_t vecs[10];

    int errors = 0;
    int checks = 0;
    int busy_cnt;
    int done_cnt;
    int hi_moves;

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic launch(input logic [1:0] op, input logic [W-1:0] d1, input logic [W-1:0] d2);
        @(negedge clk_i);
        op_i    = op;
        data1_i = d1;
        data2_i = d2;
        start_i = 1'b1;
        @(posedge clk_i);
        #1;
        start_i = 1'b0;
    endtask

    // Observe 40 cycles after E0; optionally inject a restart+mthi (kind 1) or flush (kind 2)
    task automatic watch(input int inj_at, input int kind);
        logic [W-1:0] hi_prev;
        busy_cnt = 0;
        done_cnt = 0;
        hi_moves = 0;
        hi_prev  = hi_o;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk_i);
            if (busy_o) busy_cnt++;
            if (done_o) done_cnt++;
            if (busy_o && (hi_o !== hi_prev)) hi_moves++;
            hi_prev = hi_o;
            if (k == inj_at) begin
                case (kind)
                    1: begin
                        start_i = 1'b1;
                        op_i    = OP_DIVU;
                        data1_i = 32'd9;
                        data2_i = 32'd3;
                        mthi_i  = 1'b1;
                    end
                    2: flush_i = 1'b1;
                    default: ;
                endcase
            end else begin
                start_i = 1'b0;
                mthi_i  = 1'b0;
                flush_i = 1'b0;
            end
        end
    endtask

    initial begin
        vecs[0] = '{"multu_max",   OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001};
        vecs[1] = '{"mult_neg3x7", OP_MULT,  32'hFFFFFFFD, 32'h00000007, 32'hFFFFFFFF, 32'hFFFFFFEB};
        vecs[2] = '{"mult_min_sq", OP_MULT,  32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000};
        vecs[3] = '{"div_m7_2",    OP_DIV,   32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD};
        vecs[4] = '{"divu_100_7",  OP_DIVU,  32'd100,      32'd7,        32'd2,        32'd14};
        vecs[5] = '{"divu_5_0",    OP_DIVU,  32'd5,        32'd0,        32'd5,        32'hFFFFFFFF};
        vecs[6] = '{"div_min_m1",  OP_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000};
        vecs[7] = '{"div_m7_0",    OP_DIV,   32'hFFFFFFF9, 32'h00000000, 32'hFFFFFFF9, 32'hFFFFFFFF};
        vecs[8] = '{"div_7_m2",    OP_DIV,   32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD};
        vecs[9] = '{"multu_2p32",  OP_MULTU, 32'h00010000, 32'h00010000, 32'h00000001, 32'h00000000};

        // Reset state
        #3 rst_i = 1'b0;
        repeat (2) @(negedge clk_i);
        check("rst_busy", {31'd0, busy_o}, 32'd0);
        check("rst_done", {31'd0, done_o}, 32'd0);
        check("rst_hi", hi_o, 32'h0);
        check("rst_lo", lo_o, 32'h0);
        rst_i = 1'b1;

        for (int i = 0; i < 10; i++) begin
            launch(vecs[i].op, vecs[i].d1, vecs[i].d2);
            watch(-1, 0);
            check({vecs[i].name, "_busy"}, busy_cnt, 32'd33);
            check({vecs[i].name, "_done"}, done_cnt, 32'd1);
            check({vecs[i].name, "_hi"}, hi_o, vecs[i].hi);
            check({vecs[i].name, "_lo"}, lo_o, vecs[i].lo);
        end

        // Restart and MTHI while busy are ignored
        launch(OP_MULTU, 32'd3, 32'd4);
        watch(9, 1);
        check("restart_busy", busy_cnt, 32'd33);
        check("restart_done", done_cnt, 32'd1);
        check("restart_hi_stable", hi_moves, 32'd0);
        check("restart_hi", hi_o, 32'h0);
        check("restart_lo", lo_o, 32'd12);

        // Flush mid-divide
        @(negedge clk_i);
        data1_i = 32'h0000AAAA;
        mthi_i  = 1'b1;
        @(posedge clk_i);
        #1 mthi_i = 1'b0;
        check("mthi_hi", hi_o, 32'h0000AAAA);
        launch(OP_DIVU, 32'd9, 32'd3);
        watch(19, 2);
        check("flush_busy", busy_cnt, 32'd20);
        check("flush_done", done_cnt, 32'd0);
        check("flush_hi", hi_o, 32'h0000AAAA);
        check("flush_lo", lo_o, 32'd12);
        launch(OP_DIVU, 32'd9, 32'd3);
        watch(-1, 0);
        check("post_flush_done", done_cnt, 32'd1);
        check("post_flush_hi", hi_o, 32'h0);
        check("post_flush_lo", lo_o, 32'd3);

        // Flush in IDLE drops a simultaneous start
        @(negedge clk_i);
        op_i = OP_MULTU; data1_i = 32'd2; data2_i = 32'd2;
        start_i = 1'b1; flush_i = 1'b1;
        @(posedge clk_i);
        #1 start_i = 1'b0; flush_i = 1'b0;
        check("idle_flush_busy", {31'd0, busy_o}, 32'd0);
        watch(-1, 0);
        check("idle_flush_done", done_cnt, 32'd0);
        check("idle_flush_lo", lo_o, 32'd3);

        // MT write and start on the same edge: result overwrites both
        @(negedge clk_i);
        op_i = OP_MULTU; data1_i = 32'd6; data2_i = 32'd7;
        start_i = 1'b1; mthi_i = 1'b1; mtlo_i = 1'b1;
        @(posedge clk_i);
        #1 start_i = 1'b0; mthi_i = 1'b0; mtlo_i = 1'b0;
        check("mt_start_hi", hi_o, 32'd6);
        watch(-1, 0);
        check("mt_start_hi_res", hi_o, 32'd0);
        check("mt_start_lo_res", lo_o, 32'd42);

        // Asynchronous reset mid-multiply
        @(negedge clk_i);
        data1_i = 32'h00005555; mthi_i = 1'b1;
        @(posedge clk_i);
        #1 mthi_i = 1'b0;
        launch(OP_MULT, 32'd5, 32'd6);
        repeat (14) @(negedge clk_i);
        #2 rst_i = 1'b0;
        #1;
        check("arst_hi", hi_o, 32'h0);
        check("arst_lo", lo_o, 32'h0);
        check("arst_busy", {31'd0, busy_o}, 32'd0);
        @(negedge clk_i);
        rst_i = 1'b1;
        watch(-1, 0);
        check("arst_no_done", done_cnt, 32'd0);
        check("arst_no_busy", busy_cnt, 32'd0);

        // MTLO in IDLE
        @(negedge clk_i);
        data1_i = 32'h00001234; mtlo_i = 1'b1;
        @(posedge clk_i);
        #1 mtlo_i = 1'b0;
        check("mtlo_lo", lo_o, 32'h00001234);
        check("mtlo_hi", hi_o, 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
